// File: rtl/branch_resolver.sv
// Branch resolver: carries BTB predictions from IF to EX, compares them with the
// real outcome, issues redirects, drives the BTB update port and keeps counters.
module branch_resolver #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_valid,
    input  logic [31:0]      pc_if,
    input  logic             pred_taken_if,
    input  logic [31:0]      pred_target_if,
    input  logic             stall_d,
    input  logic             stall_e,
    input  logic             flush_e,
    input  logic             is_branch_ex,
    input  logic             taken_ex,
    input  logic [31:0]      target_ex,
    output logic             redirect,
    output logic [31:0]      redirect_pc,
    output logic [31:0]      btb_pc_ex,
    output logic             btb_is_branch,
    output logic             btb_branch,
    output logic [31:0]      btb_branch_pc,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam logic [CNT_W-1:0] CntMax = '1;

    logic             dValid_q, dValid_d;
    logic [31:0]      dPc_q, dPc_d;
    logic             dPtaken_q, dPtaken_d;
    logic [31:0]      dPtarget_q, dPtarget_d;
    logic             eValid_q, eValid_d;
    logic [31:0]      ePc_q, ePc_d;
    logic             ePtaken_q, ePtaken_d;
    logic [31:0]      ePtarget_q, ePtarget_d;
    logic [CNT_W-1:0] branchCnt_q, branchCnt_d;
    logic [CNT_W-1:0] mispredCnt_q, mispredCnt_d;

    logic        resolve;
    logic        mispredTaken;
    logic        mispredNotTaken;
    logic        mispredNonBranch;
    logic [31:0] ePcPlus4;

    // Resolution is held off while EX is stalled so each instruction acts exactly once.
    always_comb begin
        resolve          = eValid_q & ~stall_e;
        ePcPlus4         = ePc_q + 32'd4;
        mispredTaken     = is_branch_ex & taken_ex & (~ePtaken_q | (ePtarget_q != target_ex));
        mispredNotTaken  = is_branch_ex & ~taken_ex & ePtaken_q;
        mispredNonBranch = ~is_branch_ex & ePtaken_q;

        redirect      = resolve & (mispredTaken | mispredNotTaken | mispredNonBranch);
        redirect_pc   = (resolve & mispredTaken) ? target_ex : ePcPlus4;
        btb_is_branch = resolve & is_branch_ex;
        btb_pc_ex     = ePc_q;
        btb_branch    = taken_ex;
        btb_branch_pc = target_ex;
        branch_cnt    = branchCnt_q;
        mispred_cnt   = mispredCnt_q;
    end

    always_comb begin
        dValid_d   = dValid_q;
        dPc_d      = dPc_q;
        dPtaken_d  = dPtaken_q;
        dPtarget_d = dPtarget_q;
        if (redirect) begin
            dValid_d = 1'b0;
        end else if (!stall_d) begin
            dValid_d   = if_valid;
            dPc_d      = pc_if;
            dPtaken_d  = pred_taken_if;
            dPtarget_d = pred_target_if;
        end

        eValid_d   = eValid_q;
        ePc_d      = ePc_q;
        ePtaken_d  = ePtaken_q;
        ePtarget_d = ePtarget_q;
        if (redirect || flush_e) begin
            eValid_d = 1'b0;
        end else if (!stall_e) begin
            eValid_d   = dValid_q;
            ePc_d      = dPc_q;
            ePtaken_d  = dPtaken_q;
            ePtarget_d = dPtarget_q;
        end

        branchCnt_d  = branchCnt_q;
        mispredCnt_d = mispredCnt_q;
        if (btb_is_branch && (branchCnt_q != CntMax)) begin
            branchCnt_d = branchCnt_q + CNT_W'(1);
        end
        if (redirect && (mispredCnt_q != CntMax)) begin
            mispredCnt_d = mispredCnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dValid_q     <= 1'b0;
            dPc_q        <= '0;
            dPtaken_q    <= 1'b0;
            dPtarget_q   <= '0;
            eValid_q     <= 1'b0;
            ePc_q        <= '0;
            ePtaken_q    <= 1'b0;
            ePtarget_q   <= '0;
            branchCnt_q  <= '0;
            mispredCnt_q <= '0;
        end else begin
            dValid_q     <= dValid_d;
            dPc_q        <= dPc_d;
            dPtaken_q    <= dPtaken_d;
            dPtarget_q   <= dPtarget_d;
            eValid_q     <= eValid_d;
            ePc_q        <= ePc_d;
            ePtaken_q    <= ePtaken_d;
            ePtarget_q   <= ePtarget_d;
            branchCnt_q  <= branchCnt_d;
            mispredCnt_q <= mispredCnt_d;
        end
    end

endmodule

// File: doc/branch_resolver.md
# branch_resolver

Tracks each BTB prediction from fetch to execute and checks it against the real branch outcome. On a misprediction it raises the front-end redirect and flush. For every resolved branch it drives the BTB update port (pc_ex / is_branch / branch / branch_pc) and keeps saturating branch and misprediction counters. It sits between the BTB lookup in IF, the hazard unit, and the branch comparator in EX of the 5-stage core.

## Interface
- CNT_W, 32, width of the performance counters
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- if_valid  in  1  IF holds a real instruction
- pc_if  in  32  PC of the IF instruction
- pred_taken_if  in  1  BTB valid_predict for pc_if
- pred_target_if  in  32  BTB pc_predict for pc_if
- stall_d  in  1  hold IF/ID tracking register
- stall_e  in  1  hold ID/EX tracking register (EX instruction not leaving)
- flush_e  in  1  hazard-unit bubble into ID/EX
- is_branch_ex  in  1  EX instruction is a branch/jump
- taken_ex  in  1  actual direction
- target_ex  in  32  actual taken target
- redirect  out  1  mispredict; flush IF/ID and ID/EX, load redirect_pc into PC
- redirect_pc  out  32  correct next PC
- btb_pc_ex  out  32  to BTB pc_ex
- btb_is_branch  out  1  to BTB is_branch (update strobe)
- btb_branch  out  1  to BTB branch
- btb_branch_pc  out  32  to BTB branch_pc
- branch_cnt  out  CNT_W  resolved branches
- mispred_cnt  out  CNT_W  redirects issued

## Operation
- Tracking registers: IF/ID = {d_valid, d_pc, d_ptaken, d_ptarget}; ID/EX = {e_valid, e_pc, e_ptaken, e_ptarget}.
- IF/ID next state, highest priority first:
  - redirect: d_valid←0.
  - stall_d: hold.
  - Otherwise: load {if_valid, pc_if, pred_taken_if, pred_target_if}.
- ID/EX next state, highest priority first:
  - redirect or flush_e: e_valid←0.
  - stall_e: hold.
  - Otherwise: load from IF/ID.
- If stall_e=1 while stall_d=0, IF/ID still advances as specified. The block does not protect against this.
- resolve = e_valid & ~stall_e. Every output below is gated by resolve. When resolve=0: redirect=0, btb_is_branch=0, and the counters hold.
- Misprediction cases, with resolve=1:
  - is_branch_ex & taken_ex & (~e_ptaken | e_ptarget≠target_ex) → redirect=1, redirect_pc=target_ex.
  - is_branch_ex & ~taken_ex & e_ptaken → redirect=1, redirect_pc=e_pc+4.
  - ~is_branch_ex & e_ptaken → redirect=1, redirect_pc=e_pc+4. btb_is_branch stays 0.
  - Any other case: redirect=0. redirect_pc is then a don't-care, driven as e_pc+4.
- e_pc+4 is 32-bit modulo: 0xFFFFFFFC+4=0x00000000.
- BTB update:
  - btb_is_branch = resolve & is_branch_ex.
  - btb_pc_ex = e_pc.
  - btb_branch = taken_ex.
  - btb_branch_pc = target_ex.
- Counters:
  - branch_cnt increments when btb_is_branch=1.
  - mispred_cnt increments when redirect=1.
  - Both saturate at 2^CNT_W−1 and never wrap.
- Reset (rst=0, asynchronous): d_valid=e_valid=0 and all tracking fields 0. Outputs then read redirect=0, redirect_pc=4, btb_is_branch=0, btb_pc_ex=0, btb_branch/btb_branch_pc follow the EX inputs, and both counters=0.
- Reset asserted mid-flight discards all in-flight predictions. No update or redirect occurs for them.

## Timing
- All outputs are combinational from the ID/EX registers and the EX inputs, valid in the same cycle. The BTB and PC register capture them at the next edge.
- An instruction fetched in cycle N resolves in cycle N+2 when there are no stalls.
- Misprediction penalty is 2 bubbles: the IF/ID and ID/EX entries squashed at the redirect edge.
- The redirect edge loads the new IF instruction into IF/ID normally on the following cycle.
- Under stall_e, resolution is deferred to the cycle in which stall_e=0. Exactly one update and at most one redirect are issued per instruction.
- flush_e and redirect together: ID/EX cleared; counters and redirect act once for the EX instruction.

## Test plan
- Correct taken prediction: pc_if=0x100, pred_taken_if=1, pred_target_if=0x200; two cycles later is_branch_ex=1, taken_ex=1, target_ex=0x200 → redirect=0, btb_is_branch=1, btb_pc_ex=0x100, branch_cnt=1, mispred_cnt=0.
- Predicted taken, actually not taken: pc=0x40, pred=1/0x80, taken_ex=0 → redirect=1, redirect_pc=0x44. Next cycle d_valid=e_valid=0 and mispred_cnt=1.
- Target mismatch plus wrap: pc=0xFFFFFFFC predicted 0x10, actual taken target 0x20 → redirect_pc=0x20. Same pc predicted taken but not taken → redirect_pc=0x00000000.
- Stall in EX: hold stall_e=1 for 3 cycles with a mispredicting branch in EX → redirect=0 and btb_is_branch=0 during the stall, then exactly one redirect and one update pulse when stall_e drops.
- Saturation with CNT_W=4: 17 mispredicting branches → branch_cnt=mispred_cnt=15.
- Asynchronous reset asserted between edges while a mispredicting branch is in ID → redirect drops immediately, counters read 0, no redirect after release.
